shift_load_sequencer: RTL and testbench



---
 rtl/shift_load_sequencer.sv | 163 ++++++++++++++++
 tb/tb_shift_load_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_load_sequencer.sv
// shift_load_sequencer: FIFO-buffered feeder that loads a word into the cyclic shifter, then idles load for SHIFTS cycles.
// Latency: word accepted at edge k drives o_load from edge k+1; back-to-back word period is 1+SHIFTS cycles.
// Backpressure: o_ready = FIFO not full; `SHIFT_LOAD_SEQ_WORDCNT_EN adds the o_word_cnt load counter.

module slq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             flush,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    input  logic             rd_en,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             push;
    logic             pop;

    // A full FIFO rejects the write even when a pop frees a slot on the same edge.
    assign wr_rdy = (cnt_q < CW'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem[rptr_q];
    assign push   = wr_vld && wr_rdy && !flush;
    assign pop    = rd_en && rd_vld && !flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wptr_q] <= wr_dat;
    end
endmodule

module shift_load_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SHIFTS = 16,
    parameter int DEPTH  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_flush,
    output logic             o_load,
    output logic [WIDTH-1:0] o_din,
    output logic             o_clr,
    output logic             o_busy,
    output logic             o_word_done
`ifdef SHIFT_LOAD_SEQ_WORDCNT_EN
    , output logic [15:0]    o_word_cnt
`endif
);
    localparam int SCW = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SCW-1:0]   shcnt_q;
    logic [SCW-1:0]   shcnt_d;
    logic             fifo_rd_vld;
    logic [WIDTH-1:0] fifo_rd_dat;
    logic             push_now;
    logic             shift_last;
    logic [WIDTH-1:0] head_dat;

    slq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .flush   (i_flush),
        .wr_vld  (i_valid),
        .wr_dat  (i_data),
        .wr_rdy  (o_ready),
        .rd_en   (state_q == LOAD),
        .rd_vld  (fifo_rd_vld),
        .rd_dat  (fifo_rd_dat)
    );

    assign push_now   = i_valid && o_ready;
    assign shift_last = (shcnt_q == SCW'(SHIFTS - 1));
    // An empty FIFO at the end of a word can still reload from a word arriving on that same edge.
    assign head_dat   = fifo_rd_vld ? fifo_rd_dat : i_data;
    assign o_busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        shcnt_d = shcnt_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_rd_vld) state_d = LOAD;
            end
            LOAD: begin
                state_d = SHIFT;
                shcnt_d = '0;
            end
            SHIFT: begin
                if (shift_last) begin
                    state_d = (fifo_rd_vld || push_now) ? LOAD : IDLE;
                    shcnt_d = '0;
                end else begin
                    shcnt_d = shcnt_q + SCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_flush) begin
            state_d = IDLE;
            shcnt_d = '0;
        end
    end

    // Outputs are registered off the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            shcnt_q     <= '0;
            o_load      <= 1'b0;
            o_din       <= '0;
            o_clr       <= 1'b0;
            o_word_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            shcnt_q     <= shcnt_d;
            o_load      <= (state_d == LOAD);
            o_clr       <= i_flush;
            o_word_done <= (state_d == SHIFT) && (shcnt_d == SCW'(SHIFTS - 1));
            if (state_d == LOAD) o_din <= head_dat;
        end
    end

`ifdef SHIFT_LOAD_SEQ_WORDCNT_EN
    // Survives flush on purpose: it counts every load ever issued since reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)              o_word_cnt <= '0;
        else if (state_d == LOAD)  o_word_cnt <= o_word_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_shift_load_sequencer.sv
// Bench for shift_load_sequencer: SHIFTS=16 and SHIFTS=1 instances, directed scenarios plus a random stream.
module tb_shift_load_sequencer;
    localparam int S = 16;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] data = '0;
    logic        ready, load, clr, busy, done;
    logic [15:0] din;
    logic        ready1, load1, clr1, busy1, done1;
    logic [15:0] din1;
`ifdef SHIFT_LOAD_SEQ_WORDCNT_EN
    logic [15:0] wcnt, wcnt1;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_load_sequencer #(.WIDTH(16), .SHIFTS(S), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(ready),
        .i_flush(flush), .o_load(load), .o_din(din), .o_clr(clr), .o_busy(busy),
        .o_word_done(done)
`ifdef SHIFT_LOAD_SEQ_WORDCNT_EN
        , .o_word_cnt(wcnt)
`endif
    );

    shift_load_sequencer #(.WIDTH(16), .SHIFTS(1), .DEPTH(D)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(ready1),
        .i_flush(flush), .o_load(load1), .o_din(din1), .o_clr(clr1), .o_busy(busy1),
        .o_word_done(done1)
`ifdef SHIFT_LOAD_SEQ_WORDCNT_EN
        , .o_word_cnt(wcnt1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (load !== 1'b0 || din !== 16'h0 || clr !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: got load=%b din=%h clr=%b done=%b busy=%b ready=%b, want 0 0000 0 0 0 1",
                     load, din, clr, done, busy, ready);
        end
        n_cmp++;
        if (load1 !== 1'b0 || din1 !== 16'h0 || clr1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state_s1: got load=%b din=%h clr=%b done=%b busy=%b ready=%b, want 0 0000 0 0 0 1",
                     load1, din1, clr1, done1, busy1, ready1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        do_reset();
        valid = 1'b1;
        data  = 16'hA5C3;
        step();
        n_cmp++;
        if (load !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_accept_cycle: got load=%b busy=%b, want 0 0", load, busy);
        end
        valid = 1'b0;
        step();
        n_cmp++;
        if (load !== 1'b1 || din !== 16'hA5C3 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_load: got load=%b din=%h busy=%b, want 1 a5c3 1", load, din, busy);
        end
        for (int i = 0; i < S; i++) begin
            step();
            n_cmp++;
            if (load !== 1'b0 || busy !== 1'b1 || done !== (i == S - 1)) begin
                n_bad++;
                $display("FAIL single_shift[%0d]: got load=%b busy=%b done=%b, want 0 1 %b", i, load, busy, done, i == S - 1);
            end
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [3];
        int          exp_t [3];
        int          nl;
        exp_d = '{16'h0001, 16'h8000, 16'hFFFF};
        exp_t = '{2, 19, 36};
        nl = 0;
        do_reset();
        for (int t = 1; t <= 45; t++) begin
            valid = (t <= 4);
            data  = (t == 1) ? 16'h0001 : (t == 2) ? 16'h8000 : 16'hFFFF;
            step();
            if (t >= 2 && t <= 4) begin
                n_cmp++;
                if (ready !== (t == 3)) begin
                    n_bad++;
                    $display("FAIL b2b_ready[t=%0d]: got %b want %b", t, ready, t == 3);
                end
            end
            if (load === 1'b1) begin
                n_cmp++;
                if (nl >= 3 || din !== exp_d[nl] || t != exp_t[nl]) begin
                    n_bad++;
                    $display("FAIL b2b_load[%0d]: got din=%h at t=%0d, want din=%h at t=%0d",
                             nl, din, t, (nl < 3) ? exp_d[nl] : 16'hxxxx, (nl < 3) ? exp_t[nl] : -1);
                end
                nl++;
            end
        end
        n_cmp++;
        if (nl != 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d loads want 3", nl);
        end
    endtask

    task automatic test_flush();
        int loads;
        do_reset();
        valid = 1'b1;
        data  = 16'h1111;
        step();
        data = 16'h2222;
        step();
        valid = 1'b0;
        repeat (5) step();
        flush = 1'b1;
        valid = 1'b1;
        data  = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (clr !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || load !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL flush[%0d]: got clr=%b busy=%b ready=%b load=%b done=%b, want 1 0 1 0 0",
                         i, clr, busy, ready, load, done);
            end
        end
        flush = 1'b0;
        valid = 1'b0;
        step();
        n_cmp++;
        if (clr !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_clr_end: got clr=%b want 0", clr);
        end
        loads = 0;
        repeat (40) begin
            step();
            if (load === 1'b1) loads++;
        end
        n_cmp++;
        if (loads != 0 || busy !== 1'b0 || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_drop: got loads=%0d busy=%b ready=%b, want 0 0 1", loads, busy, ready);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        valid = 1'b1;
        data  = 16'hBEEF;
        step();
        data = 16'hCAFE;
        step();
        valid = 1'b0;
        repeat (3) step();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (load !== 1'b0 || din !== 16'h0 || clr !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got load=%b din=%h clr=%b done=%b busy=%b ready=%b, want 0 0000 0 0 0 1",
                     load, din, clr, done, busy, ready);
        end
        #1 rst_n = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            n_bad++;
            $display("FAIL async_after: got busy=%b load=%b, want 0 0", busy, load);
        end
        valid = 1'b1;
        data  = 16'h1234;
        step();
        valid = 1'b0;
        step();
        n_cmp++;
        if (load !== 1'b1 || din !== 16'h1234) begin
            n_bad++;
            $display("FAIL async_reload: got load=%b din=%h, want 1 1234", load, din);
        end
    endtask

    task automatic test_shifts1();
        logic [15:0] q[$];
        logic [15:0] d;
        logic [15:0] e;
        logic        r;
        logic        exp_load;
        do_reset();
        for (int t = 1; t <= 30; t++) begin
            d     = 16'($urandom);
            r     = ready1;
            valid = 1'b1;
            data  = d;
            step();
            if (r === 1'b1) q.push_back(d);
            if (t >= 2) begin
                exp_load = (t % 2 == 0);
                n_cmp++;
                if (load1 !== exp_load || done1 !== !exp_load || busy1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL s1_pattern[t=%0d]: got load=%b done=%b busy=%b, want %b %b 1",
                             t, load1, done1, busy1, exp_load, !exp_load);
                end
                if (exp_load) begin
                    e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                    n_cmp++;
                    if (din1 !== e) begin
                        n_bad++;
                        $display("FAIL s1_data[t=%0d]: got %h want %h", t, din1, e);
                    end
                end
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_random();
        int          at[$];
        int          lt[$];
        logic [15:0] wd[$];
        int          prev;
        int          c;
        int          cnt;
        int          nl;
        bit          v;
        bit          ready_e, load_e, done_e, busy_e;
        logic [15:0] d;
        logic [15:0] din_e;
        do_reset();
        prev    = -1000;
        ready_e = 1'b1;
        for (int n = 0; n < 440; n++) begin
            v     = (n < 400) && ($urandom_range(0, (n < 200) ? 14 : 2) == 0);
            d     = 16'($urandom);
            valid = v;
            data  = d;
            step();
            c = n + 1;
            // A word loads right away if it lands on or before the end of the previous word, else one cycle later.
            if (v && ready_e) begin
                nl = (c <= prev + S + 1) ? prev + S + 1 : c + 1;
                at.push_back(c);
                lt.push_back(nl);
                wd.push_back(d);
                prev = nl;
            end
            cnt = 0; load_e = 0; done_e = 0; busy_e = 0; din_e = '0;
            foreach (lt[i]) begin
                if (at[i] <= c) cnt++;
                if (lt[i] + 1 <= c) cnt--;
                if (lt[i] == c) begin
                    load_e = 1;
                    din_e  = wd[i];
                end
                if (lt[i] + S == c) done_e = 1;
                if (lt[i] <= c && c <= lt[i] + S) busy_e = 1;
            end
            ready_e = (cnt < D);
            n_cmp++;
            if (ready !== ready_e || load !== load_e || done !== done_e || busy !== busy_e ||
                (load_e && din !== din_e)) begin
                n_bad++;
                $display("FAIL random[c=%0d]: got ready=%b load=%b done=%b busy=%b din=%h, want %b %b %b %b %h",
                         c, ready, load, done, busy, din, ready_e, load_e, done_e, busy_e, din_e);
            end
        end
        valid = 1'b0;
    endtask

`ifdef SHIFT_LOAD_SEQ_WORDCNT_EN
    task automatic test_word_cnt();
        do_reset();
        n_cmp++;
        if (wcnt !== 16'd0 || wcnt1 !== 16'd0) begin
            n_bad++;
            $display("FAIL wcnt_reset: got %h/%h want 0000/0000", wcnt, wcnt1);
        end
        valid = 1'b1;
        data  = 16'h0F0F;
        step();
        step();
        valid = 1'b0;
        repeat (40) step();
        n_cmp++;
        if (wcnt !== 16'd2) begin
            n_bad++;
            $display("FAIL wcnt_two: got %h want 0002", wcnt);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_cmp++;
        if (wcnt !== 16'd2) begin
            n_bad++;
            $display("FAIL wcnt_flush: got %h want 0002", wcnt);
        end
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        n_cmp++;
        if (wcnt !== 16'd3) begin
            n_bad++;
            $display("FAIL wcnt_three: got %h want 0003", wcnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wcnt !== 16'd0) begin
            n_bad++;
            $display("FAIL wcnt_async_reset: got %h want 0000", wcnt);
        end
        #1 rst_n = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_shifts1();
        test_random();
`ifdef SHIFT_LOAD_SEQ_WORDCNT_EN
        test_word_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
